reg_write_scheduler: RTL and testbench

// Owns the single write port of the 8x16 register file. Arbitrates that port between the pipeline

---
 rtl/reg_write_scheduler_if.sv | 45 ++++
 rtl/reg_write_scheduler.sv | 154 +++++++++++++++
 tb/tb_reg_write_scheduler.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_write_scheduler_if.sv
// ============================================================================
// Module   : reg_write_scheduler_if
// Brief    : Bundle of the WB/LU/issue/read-stage and regfile-side signals
//            around the register-file write-port scheduler.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface reg_write_scheduler_if #(
    parameter int DW = 16,
    parameter int AW = 3
);
    logic              wb_valid;
    logic [AW-1:0]     wb_rd;
    logic [DW-1:0]     wb_data;
    logic              wb_ready;
    logic              lu_valid;
    logic [AW-1:0]     lu_rd;
    logic [DW-1:0]     lu_data;
    logic              lu_ready;
    logic              iss_valid;
    logic [AW-1:0]     iss_rd;
    logic [AW-1:0]     rd_ra;
    logic [AW-1:0]     rd_rb;
    logic              stall;
    logic              reg_write;
    logic [AW-1:0]     reg_rd;
    logic [DW-1:0]     reg_wdata;
    logic [2**AW-1:0]  busy;

    modport master (
        output wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
               iss_valid, iss_rd, rd_ra, rd_rb,
        input  wb_ready, lu_ready, stall, reg_write, reg_rd, reg_wdata, busy
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
               iss_valid, iss_rd, rd_ra, rd_rb,
        output wb_ready, lu_ready, stall, reg_write, reg_rd, reg_wdata, busy
    );
endinterface

`default_nettype wire

// File: rtl/reg_write_scheduler.sv
// ============================================================================
// Module   : reg_write_scheduler
// Brief    : Arbitrates the single regfile write port between WB and a FIFO of
//            long-latency results, with anti-starvation and a busy scoreboard.
//            Optional macro REG_SCHED_R0_PROTECT_EN makes r0 unwritable/never busy.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module reg_write_scheduler #(
    parameter int DW           = 16,
    parameter int AW           = 3,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    reg_write_scheduler_if.slave bus
);
    localparam int               c_NREG  = 2**AW;
    localparam int               c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int               c_CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_PTR_W:0]   c_PTR_ONE = (c_PTR_W+1)'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_LIMIT   = c_CNT_W'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_STARVE = 1'b1
    } state_t;

    state_t             r_state;
    logic [DW-1:0]      r_fifo_data [FIFO_DEPTH];
    logic [AW-1:0]      r_fifo_rd   [FIFO_DEPTH];
    logic [c_PTR_W:0]   r_wptr;
    logic [c_PTR_W:0]   r_rptr;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_NREG-1:0]  r_busy;
    logic               r_reg_write;
    logic [AW-1:0]      r_reg_rd;
    logic [DW-1:0]      r_reg_wdata;

    logic               w_empty;
    logic               w_full;
    logic               w_fifo_grant;
    logic               w_wb_grant;
    logic               w_lu_ready;
    logic               w_enq;
    logic [AW-1:0]      w_sel_rd;
    logic [DW-1:0]      w_sel_data;
    logic               w_wr_en;
    logic               w_iss_en;
    logic               w_stall;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [c_NREG-1:0]  w_busy_next;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_PTR_W] != r_rptr[c_PTR_W]) &&
                     (r_wptr[c_PTR_W-1:0] == r_rptr[c_PTR_W-1:0]);

    // The two grants are mutually exclusive: in NORMAL the head only wins with no WB request.
    assign w_fifo_grant = !w_empty && ((r_state == ST_STARVE) || !bus.wb_valid);
    assign w_wb_grant   = bus.wb_valid && (r_state == ST_NORMAL);
    assign w_lu_ready   = !w_full || w_fifo_grant;
    assign w_enq        = bus.lu_valid && w_lu_ready;

    assign w_sel_rd   = w_wb_grant ? bus.wb_rd   : r_fifo_rd[r_rptr[c_PTR_W-1:0]];
    assign w_sel_data = w_wb_grant ? bus.wb_data : r_fifo_data[r_rptr[c_PTR_W-1:0]];

`ifdef REG_SCHED_R0_PROTECT_EN
    assign w_wr_en  = (w_wb_grant || w_fifo_grant) && (w_sel_rd != '0);
    assign w_iss_en = bus.iss_valid && (bus.iss_rd != '0);
    assign w_stall  = ((bus.rd_ra != '0) && r_busy[bus.rd_ra]) ||
                      ((bus.rd_rb != '0) && r_busy[bus.rd_rb]);
`else
    assign w_wr_en  = w_wb_grant || w_fifo_grant;
    assign w_iss_en = bus.iss_valid;
    assign w_stall  = r_busy[bus.rd_ra] || r_busy[bus.rd_rb];
`endif

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_fifo_grant || w_empty) begin
            w_cnt_next = '0;
        end else if (r_cnt != c_LIMIT) begin
            w_cnt_next = r_cnt + c_CNT_ONE;
        end
    end

    // Commit clears first so a same-edge issue to the same index leaves it busy.
    always_comb begin
        w_busy_next = r_busy;
        if (r_reg_write) begin
            w_busy_next[r_reg_rd] = 1'b0;
        end
        if (w_iss_en) begin
            w_busy_next[bus.iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_fifo_rd[r_wptr[c_PTR_W-1:0]]   <= bus.lu_rd;
            r_fifo_data[r_wptr[c_PTR_W-1:0]] <= bus.lu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_NORMAL;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_cnt       <= '0;
            r_busy      <= '0;
            r_reg_write <= 1'b0;
            r_reg_rd    <= '0;
            r_reg_wdata <= '0;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_fifo_grant) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            r_cnt  <= w_cnt_next;
            r_busy <= w_busy_next;

            r_reg_write <= w_wr_en;
            if (w_wr_en) begin
                r_reg_rd    <= w_sel_rd;
                r_reg_wdata <= w_sel_data;
            end

            // Switch on the edge recording the LIMIT-th loss so the head wins the very next cycle.
            case (r_state)
                ST_NORMAL: if ((w_cnt_next == c_LIMIT) && !w_empty) r_state <= ST_STARVE;
                ST_STARVE: if (w_fifo_grant) r_state <= ST_NORMAL;
                default:   r_state <= ST_NORMAL;
            endcase
        end
    end

    assign bus.wb_ready  = w_wb_grant;
    assign bus.lu_ready  = w_lu_ready;
    assign bus.stall     = w_stall;
    assign bus.reg_write = r_reg_write;
    assign bus.reg_rd    = r_reg_rd;
    assign bus.reg_wdata = r_reg_wdata;
    assign bus.busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_reg_write_scheduler.sv
// ============================================================================
// Module   : tb_reg_write_scheduler
// Brief    : Randomized scoreboard bench for reg_write_scheduler against a
//            queue-based behavioural model of arbitration and scoreboarding.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_reg_write_scheduler;
    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;
    localparam int NR    = 2**AW;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_write_scheduler_if #(.DW(DW), .AW(AW)) bus ();

    reg_write_scheduler #(
        .DW(DW), .AW(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    wr_t           sb_q[$];
    wr_t           lu_q[$];
    int            losses;
    logic [NR-1:0] mbusy;
    logic          commit_v;
    logic [AW-1:0] commit_rd;
    logic          wb_pend;
    logic          lu_pend;
    wr_t           mon_e;
    logic          mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic writes_reg(input logic [AW-1:0] rd);
`ifdef REG_SCHED_R0_PROTECT_EN
        return rd != '0;
`else
        return rd == rd;
`endif
    endfunction

    // Every committed write must match the oldest granted request, one cycle later.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            mon_exp = (sb_q.size() != 0);
            check("reg_write", 32'(bus.reg_write), 32'(mon_exp));
            if (mon_exp) begin
                mon_e = sb_q.pop_front();
                if (bus.reg_write) begin
                    check("reg_rd", 32'(bus.reg_rd), 32'(mon_e.rd));
                    check("reg_wdata", 32'(bus.reg_wdata), 32'(mon_e.data));
                end
            end
        end
    end

    task automatic cycle(input int wb_pct, input int lu_pct, input int iss_pct);
        logic          fifo_pri, fifo_g, wb_g, exp_lr;
        logic [AW-1:0] r;
        wr_t           w;
        @(negedge clk);
        if (!wb_pend && ($urandom_range(99) < 32'(wb_pct))) begin
            wb_pend     = 1'b1;
            bus.wb_rd   = AW'($urandom);
            bus.wb_data = DW'($urandom);
        end
        if (!lu_pend && ($urandom_range(99) < 32'(lu_pct))) begin
            lu_pend     = 1'b1;
            bus.lu_rd   = AW'($urandom);
            bus.lu_data = DW'($urandom);
        end
        bus.wb_valid  = wb_pend;
        bus.lu_valid  = lu_pend;
        r             = AW'($urandom);
        bus.iss_rd    = r;
        bus.iss_valid = !mbusy[r] && ($urandom_range(99) < 32'(iss_pct));
        bus.rd_ra     = AW'($urandom);
        bus.rd_rb     = AW'($urandom);
        #1;
        fifo_pri = (lu_q.size() != 0) && (losses >= LIMIT);
        fifo_g   = (lu_q.size() != 0) && (fifo_pri || !wb_pend);
        wb_g     = wb_pend && !fifo_pri;
        exp_lr   = (lu_q.size() < DEPTH) || fifo_g;
        check("wb_ready", 32'(bus.wb_ready), 32'(wb_g));
        check("lu_ready", 32'(bus.lu_ready), 32'(exp_lr));
        check("stall", 32'(bus.stall), 32'(mbusy[bus.rd_ra] | mbusy[bus.rd_rb]));
        check("busy", 32'(bus.busy), 32'(mbusy));

        w = '0;
        if (wb_g)        w = '{rd: bus.wb_rd, data: bus.wb_data};
        else if (fifo_g) w = lu_q[0];
        if ((wb_g || fifo_g) && writes_reg(w.rd)) sb_q.push_back(w);

        if (fifo_g || (lu_q.size() == 0)) losses = 0;
        else if (losses < LIMIT)          losses++;
        if (fifo_g) void'(lu_q.pop_front());
        if (lu_pend && exp_lr) begin
            lu_q.push_back('{rd: bus.lu_rd, data: bus.lu_data});
            lu_pend = 1'b0;
        end
        if (wb_g) wb_pend = 1'b0;

        if (commit_v) mbusy[commit_rd] = 1'b0;
        if (bus.iss_valid && writes_reg(bus.iss_rd)) mbusy[bus.iss_rd] = 1'b1;
        commit_v  = (wb_g || fifo_g) && writes_reg(w.rd);
        commit_rd = w.rd;
    endtask

    task automatic model_clear();
        sb_q.delete();
        lu_q.delete();
        losses   = 0;
        mbusy    = '0;
        commit_v = 1'b0;
        wb_pend  = 1'b0;
        lu_pend  = 1'b0;
    endtask

    // Asynchronous reset mid-traffic: outputs clear without waiting for a clock edge.
    task automatic reset_mid();
        @(negedge clk);
        bus.wb_valid  = 1'b0;
        bus.lu_valid  = 1'b0;
        bus.iss_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_reg_write", 32'(bus.reg_write), 32'd0);
        check("rst_reg_rd", 32'(bus.reg_rd), 32'd0);
        check("rst_reg_wdata", 32'(bus.reg_wdata), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_lu_ready", 32'(bus.lu_ready), 32'd1);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
        bus.lu_valid = 1'b0; bus.lu_rd = '0; bus.lu_data = '0;
        bus.iss_valid = 1'b0; bus.iss_rd = '0;
        bus.rd_ra = '0; bus.rd_rb = '0;
        model_clear();
        #1;
        check("init_reg_write", 32'(bus.reg_write), 32'd0);
        check("init_reg_rd", 32'(bus.reg_rd), 32'd0);
        check("init_reg_wdata", 32'(bus.reg_wdata), 32'd0);
        check("init_busy", 32'(bus.busy), 32'd0);
        check("init_stall", 32'(bus.stall), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed single WB write: rd=3, data=16'h1234.
        wb_pend     = 1'b1;
        bus.wb_rd   = 3'd3;
        bus.wb_data = 16'h1234;
        cycle(0, 0, 0);
        repeat (3) cycle(0, 0, 0);

        repeat (300) cycle(95, 60, 30);
        reset_mid();
        repeat (300) cycle(50, 50, 40);
        reset_mid();
        repeat (300) cycle(20, 85, 50);
        repeat (8) cycle(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
